// File: rtl/conf_int_add_arbiter_if.sv
// Request/response bundle between the accelerator requesters, the arbiter and the result consumer.
// The requesters and consumer connect to the master modport; the arbiter connects to the slave modport.
interface conf_int_add_arbiter_if #(
  parameter int W = 32
);
  // valid/ready: a transfer completes on a rising clock edge where both are high; the
  // source raises valid and holds it, with its payload stable, until that edge.
  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [W-1:0] rsp_d;

  modport slave (
    input  req0_valid, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_a, req1_b,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_d,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_a, req1_b,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_d,
    output rsp_ready
  );
endinterface

// File: rtl/conf_int_add_arbiter.sv
// Round-robin arbiter for two requesters sharing one combinational adder. It applies
// per-requester precision by masking operand and result LSBs, and returns results with their owner id.
module conf_int_add_arbiter #(
  parameter int DATA_PATH_BITWIDTH = 32,
  parameter int PREC_W             = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  conf_int_add_arbiter_if.slave         bus,
  input  logic                          cfg_we,
  input  logic                          cfg_id,
  input  logic [PREC_W-1:0]             cfg_prec,
  output logic [DATA_PATH_BITWIDTH-1:0] add_a,
  output logic [DATA_PATH_BITWIDTH-1:0] add_b,
  input  logic [DATA_PATH_BITWIDTH-1:0] add_d,
  output logic                          busy,
  output logic [1:0]                    dbg_state
);
  localparam int W = DATA_PATH_BITWIDTH;
  localparam logic [PREC_W-1:0] PREC_MAX = PREC_W'(W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              last_gnt_q;
  logic              owner_q;
  logic              rsp_id_q;
  logic [W-1:0]      mask_q;
  logic [W-1:0]      rsp_d_q;
  logic [PREC_W-1:0] prec0_q, prec1_q;

  logic              gnt;
  logic              gnt_id;
  logic [W-1:0]      gnt_a, gnt_b, gnt_mask;

  function automatic logic [PREC_W-1:0] clamp_prec(input logic [PREC_W-1:0] p);
    if (p == '0) return PREC_W'(1);
    if (p > PREC_MAX) return PREC_MAX;
    return p;
  endfunction

  // Keep the top p bits: shifting ones left by (W - p) clears the dropped LSBs.
  function automatic logic [W-1:0] prec_mask(input logic [PREC_W-1:0] p);
    logic [PREC_W-1:0] drop;
    drop = PREC_MAX - p;
    return {W{1'b1}} << drop;
  endfunction

  // Winner selection: on a tie, the requester that did not win last time goes next.
  always_comb begin
    gnt_id = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      gnt_id = ~last_gnt_q;
    end else if (bus.req1_valid) begin
      gnt_id = 1'b1;
    end
    gnt      = (state_q == IDLE) && !rst && (bus.req0_valid || bus.req1_valid);
    gnt_a    = gnt_id ? bus.req1_a : bus.req0_a;
    gnt_b    = gnt_id ? bus.req1_b : bus.req0_b;
    gnt_mask = prec_mask(gnt_id ? prec1_q : prec0_q);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (gnt) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      owner_q    <= 1'b0;
      mask_q     <= '1;
      rsp_d_q    <= '0;
      rsp_id_q   <= 1'b0;
      add_a      <= '0;
      add_b      <= '0;
      prec0_q    <= PREC_MAX;
      prec1_q    <= PREC_MAX;
    end else begin
      state_q <= state_d;
      // A write in a grant cycle lands after the grant has already used the old value.
      if (cfg_we) begin
        if (cfg_id) prec1_q <= clamp_prec(cfg_prec);
        else        prec0_q <= clamp_prec(cfg_prec);
      end
      if (gnt) begin
        add_a      <= gnt_a & gnt_mask;
        add_b      <= gnt_b & gnt_mask;
        owner_q    <= gnt_id;
        mask_q     <= gnt_mask;
        last_gnt_q <= gnt_id;
      end
      if (state_q == EXEC) begin
        rsp_d_q  <= add_d & mask_q;
        rsp_id_q <= owner_q;
      end
    end
  end

  assign bus.req0_ready = gnt && !gnt_id;
  assign bus.req1_ready = gnt && gnt_id;
  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_d      = rsp_d_q;
  assign bus.rsp_id     = rsp_id_q;
  assign busy           = (state_q != IDLE);
  assign dbg_state      = state_q;
endmodule

// File: tb/tb_conf_int_add_arbiter.sv
// Bench for conf_int_add_arbiter: directed cases plus randomized traffic, checked by a
// queue-based scoreboard against a precision/round-robin reference model.
module tb_conf_int_add_arbiter;
  localparam int W      = 32;
  localparam int PREC_W = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_we = 1'b0;
  logic              cfg_id = 1'b0;
  logic [PREC_W-1:0] cfg_prec = '0;
  logic [W-1:0]      add_a, add_b, add_d;
  logic              busy;
  logic [1:0]        dbg_state;

  conf_int_add_arbiter_if #(.W(W)) ifc ();

  conf_int_add_arbiter #(.DATA_PATH_BITWIDTH(W), .PREC_W(PREC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (ifc.slave),
    .cfg_we    (cfg_we),
    .cfg_id    (cfg_id),
    .cfg_prec  (cfg_prec),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_d     (add_d),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Shared no-flip-flop adder
  assign add_d = add_a + add_b;

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish before 200000");
    $fatal(1, "timeout");
  end

  // ---------------- reference model state and scoreboard ----------------
  int              errors = 0;
  int              checks = 0;
  logic [W:0]      exp_q[$];
  int              t_q[$];
  int              mprec[2];
  int              m_last;
  int              g_cnt[2];
  int              g_first;
  logic            pend[2];
  logic [W-1:0]    pa[2], pb[2];

  logic              d_rst, d_rsp_ready, d_cfg_we, d_cfg_id;
  logic [PREC_W-1:0] d_cfg_prec;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int clamp_ref(input int p);
    if (p < 1) return 1;
    if (p > W) return W;
    return p;
  endfunction

  function automatic logic [W-1:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b, input int p);
    logic [63:0] keep;
    logic [W-1:0] m, s;
    keep = (64'd1 << W) - (64'd1 << (W - p));
    m = keep[W-1:0];
    s = (a & m) + (b & m);
    return s & m;
  endfunction

  // ---------------- driver ----------------
  // One cycle: drive at negedge, then predict and check the grant combinationally.
  task automatic step();
    logic [1:0] exp_rdy;
    int w;
    @(negedge clk);
    rst            = d_rst;
    ifc.rsp_ready  = d_rsp_ready;
    cfg_we         = d_cfg_we;
    cfg_id         = d_cfg_id;
    cfg_prec       = d_cfg_prec;
    ifc.req0_valid = pend[0];
    ifc.req0_a     = pa[0];
    ifc.req0_b     = pb[0];
    ifc.req1_valid = pend[1];
    ifc.req1_a     = pa[1];
    ifc.req1_b     = pb[1];
    #1;
    exp_rdy = 2'b00;
    w = -1;
    if (!d_rst && exp_q.size() == 0 && (pend[0] || pend[1])) begin
      if (pend[0] && pend[1]) w = 1 - m_last;
      else                    w = pend[1] ? 1 : 0;
      exp_rdy[w] = 1'b1;
    end
    check("req_ready", {62'd0, ifc.req1_ready, ifc.req0_ready}, {62'd0, exp_rdy});
    if (w >= 0) begin
      exp_q.push_back({1'(w), ref_sum(pa[w], pb[w], mprec[w])});
      t_q.push_back(cyc);
      if (g_first < 0) g_first = w;
      g_cnt[w]++;
      m_last  = w;
      pend[w] = 1'b0;
    end
    if (d_rst) begin
      exp_q.delete();
      t_q.delete();
      mprec[0] = W;
      mprec[1] = W;
      m_last   = 1;
    end else if (d_cfg_we) begin
      mprec[d_cfg_id] = clamp_ref(int'(d_cfg_prec));
    end
    d_cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    d_rst = 1'b1;
    step();
    step();
    d_rst = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0 && !pend[0] && !pend[1]) break;
      step();
    end
    check("drain_outstanding", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic set_cfg(input logic id, input int p);
    d_cfg_we   = 1'b1;
    d_cfg_id   = id;
    d_cfg_prec = PREC_W'(p);
  endtask

  task automatic run_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_d, input string name);
    pend[id] = 1'b1;
    pa[id]   = a;
    pb[id]   = b;
    step();
    step();
    step();
    check({name, "_valid"}, 64'(ifc.rsp_valid), 64'd1);
    check({name, "_id"}, 64'(ifc.rsp_id), 64'(id));
    check(name, 64'(ifc.rsp_d), 64'(exp_d));
    wait_idle();
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    logic         prev_v;
    logic         prev_hs;
    logic [W-1:0] held_d;
    logic         held_id;
    logic [W:0]   exp;
    prev_v  = 1'b0;
    prev_hs = 1'b0;
    held_d  = '0;
    held_id = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev_v  = 1'b0;
        prev_hs = 1'b0;
      end else begin
        if (ifc.rsp_valid) begin
          if (!prev_v || prev_hs) begin
            if (exp_q.size() == 0) begin
              check("unexpected_rsp", 64'd1, 64'd0);
            end else begin
              check("rsp_latency", 64'(cyc - t_q[0]), 64'd2);
            end
            held_d  = ifc.rsp_d;
            held_id = ifc.rsp_id;
          end else begin
            check("hold_rsp_d", 64'(ifc.rsp_d), 64'(held_d));
            check("hold_rsp_id", 64'(ifc.rsp_id), 64'(held_id));
          end
          if (ifc.rsp_ready && exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            void'(t_q.pop_front());
            check("rsp_id", 64'(ifc.rsp_id), 64'(exp[W]));
            check("rsp_d", 64'(ifc.rsp_d), 64'(exp[W-1:0]));
          end
        end
        prev_v  = ifc.rsp_valid;
        prev_hs = ifc.rsp_valid && ifc.rsp_ready;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    mprec[0] = W;  mprec[1] = W;  m_last = 1;
    g_cnt[0] = 0;  g_cnt[1] = 0;  g_first = -1;
    pend[0] = 1'b0;  pend[1] = 1'b0;
    pa[0] = '0;  pa[1] = '0;  pb[0] = '0;  pb[1] = '0;
    d_rst = 1'b1;  d_rsp_ready = 1'b1;  d_cfg_we = 1'b0;  d_cfg_id = 1'b0;  d_cfg_prec = '0;
    ifc.req0_valid = 1'b0;  ifc.req1_valid = 1'b0;  ifc.rsp_ready = 1'b0;
    ifc.req0_a = '0;  ifc.req0_b = '0;  ifc.req1_a = '0;  ifc.req1_b = '0;

    do_reset();
    step();
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_rsp_valid", 64'(ifc.rsp_valid), 64'd0);
    check("reset_state", 64'(dbg_state), 64'd0);
    check("reset_add_a", 64'(add_a), 64'd0);
    check("reset_rsp_d", 64'(ifc.rsp_d), 64'd0);

    // Basic op with timing: grant, EXEC operands, RESP result, then idle again
    pend[0] = 1'b1;  pa[0] = 32'd5;  pb[0] = 32'd7;
    step();
    step();
    check("basic_add_a", 64'(add_a), 64'd5);
    check("basic_add_b", 64'(add_b), 64'd7);
    check("basic_busy_exec", 64'(busy), 64'd1);
    step();
    check("basic_rsp_valid", 64'(ifc.rsp_valid), 64'd1);
    check("basic_rsp_d", 64'(ifc.rsp_d), 64'd12);
    check("basic_rsp_id", 64'(ifc.rsp_id), 64'd0);
    step();
    check("basic_busy_after", 64'(busy), 64'd0);

    // Back-to-back contention from reset: alternating grants starting with requester 0
    do_reset();
    g_cnt[0] = 0;  g_cnt[1] = 0;  g_first = -1;
    for (int i = 0; i < 60; i++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r]) begin
          pend[r] = 1'b1;  pa[r] = $urandom;  pb[r] = $urandom;
        end
      end
      step();
    end
    pend[0] = 1'b0;  pend[1] = 1'b0;
    wait_idle();
    check("rr_first_winner", 64'(g_first), 64'd0);
    check("rr_grants_req0", 64'(g_cnt[0]), 64'd10);
    check("rr_grants_req1", 64'(g_cnt[1]), 64'd10);

    // Precision and clamp cases
    set_cfg(1'b1, 24);
    step();
    pend[1] = 1'b1;  pa[1] = 32'h0000_01FF;  pb[1] = 32'h0000_0101;
    step();
    step();
    check("p24_add_a", 64'(add_a), 64'h100);
    check("p24_add_b", 64'(add_b), 64'h100);
    step();
    check("p24_rsp_d", 64'(ifc.rsp_d), 64'h200);
    wait_idle();
    set_cfg(1'b0, 0);
    step();
    run_op(0, 32'h8000_0001, 32'h7FFF_FFFF, 32'h8000_0000, "clamp0");
    set_cfg(1'b0, 40);
    step();
    run_op(0, 32'h0000_01FF, 32'h0000_0101, 32'h0000_0300, "clamp40");
    run_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, "wrap");
    // A config write in the grant cycle only affects the following grant
    set_cfg(1'b0, 1);
    run_op(0, 32'h0000_01FF, 32'h0000_0101, 32'h0000_0300, "cfg_same_cycle");
    run_op(0, 32'h8000_0001, 32'h7FFF_FFFF, 32'h8000_0000, "cfg_next_grant");

    // Consumer stall: response held, both requesters wait
    d_rsp_ready = 1'b0;
    pend[0] = 1'b1;  pa[0] = $urandom;  pb[0] = $urandom;
    pend[1] = 1'b1;  pa[1] = $urandom;  pb[1] = $urandom;
    for (int i = 0; i < 12; i++) step();
    check("stall_rsp_valid", 64'(ifc.rsp_valid), 64'd1);
    check("stall_busy", 64'(busy), 64'd1);
    d_rsp_ready = 1'b1;
    step();
    step();
    wait_idle();

    // Reset while EXEC discards the operation and restores precision
    set_cfg(1'b1, 24);
    step();
    pend[0] = 1'b1;  pa[0] = 32'h1234_5678;  pb[0] = 32'h1111_1111;
    step();
    d_rst = 1'b1;
    step();
    d_rst = 1'b0;
    step();
    check("rst_exec_busy", 64'(busy), 64'd0);
    check("rst_exec_state", 64'(dbg_state), 64'd0);
    check("rst_exec_rsp_valid", 64'(ifc.rsp_valid), 64'd0);
    check("rst_exec_add_a", 64'(add_a), 64'd0);
    check("rst_exec_add_b", 64'(add_b), 64'd0);
    check("rst_exec_rsp_d", 64'(ifc.rsp_d), 64'd0);
    check("rst_exec_rsp_id", 64'(ifc.rsp_id), 64'd0);
    for (int i = 0; i < 4; i++) step();
    run_op(1, 32'h0000_01FF, 32'h0000_0101, 32'h0000_0300, "rst_prec1");

    // Randomized traffic with random back-pressure and config writes
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 3) != 0) begin
          pend[r] = 1'b1;  pa[r] = $urandom;  pb[r] = $urandom;
        end
      end
      d_rsp_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) == 0) set_cfg(1'($urandom_range(0, 1)), int'($urandom_range(0, 63)));
      step();
    end
    d_rsp_ready = 1'b1;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/conf_int_add_arbiter.md
# conf_int_add_arbiter

Two-requester round-robin arbiter and precision sequencer for one shared no-flip-flop configurable integer adder (`conf_int_add__noFF__arch_agnos`). It accepts operand pairs over valid/ready handshakes and applies a per-requester programmable precision by zeroing operand and result LSBs. It drives the shared adder's operands from registers, captures the combinational sum, and returns it with the requester ID. It sits between accelerator requesters and the single adder instance.

## Interface
- `DATA_PATH_BITWIDTH`, 32, width of operands, adder ports and result.
- `PREC_W`, 6, width of the precision config field; must satisfy 2^PREC_W > DATA_PATH_BITWIDTH.

Ports (W = `DATA_PATH_BITWIDTH`):
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has an operand pair.
- `req0_ready`  out  1  requester 0 pair accepted this cycle.
- `req0_a`, `req0_b`  in  W  requester 0 operands, two's complement.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`  same as requester 0, for requester 1.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_id`  out  1  requester that owns the result.
- `rsp_d`  out  W  masked sum.
- `cfg_we`  in  1  precision write strobe.
- `cfg_id`  in  1  precision register select.
- `cfg_prec`  in  PREC_W  number of significant MSBs to keep.
- `add_a`, `add_b`  out  W  registered operands to the shared adder.
- `add_d`  in  W  combinational sum from the shared adder.
- `busy`  out  1  high in any state except IDLE.

## Operation
- Precision registers `prec0` and `prec1`:
  - Reset value: W.
  - On `cfg_we`, `prec[cfg_id]` is written with the clamped value: 0 becomes 1, values above W become W.
  - Writes are accepted in any state.
  - A write takes effect at the next grant. The in-flight operation keeps the precision latched at its grant.
- Mask: `mask = ~((1 << (W - prec)) - 1)`. prec = W gives all ones; prec = 1 keeps only the MSB.
- FSM states: IDLE, EXEC, RESP.
  - **IDLE, no `reqN_valid`:** stay in IDLE.
  - **IDLE, grant:** pick the winner.
    - If only one requester is valid, it wins.
    - If both are valid, the requester not equal to `last_gnt` wins.
    - `last_gnt` resets to 1, so requester 0 wins the first tie.
  - **IDLE, on grant:**
    - `reqN_ready` = 1 for the winner, for exactly this cycle.
    - Register `add_a <= reqN_a & mask` and `add_b <= reqN_b & mask`.
    - Latch owner ID and mask; update `last_gnt`; go to EXEC.
  - **EXEC:** capture `rsp_d <= add_d & mask_latched` and `rsp_id <= owner`; go to RESP.
  - **RESP:** `rsp_valid` = 1.
    - When `rsp_ready` = 1, go to IDLE.
    - Otherwise hold; `rsp_d`, `rsp_id`, `add_a` and `add_b` stay stable.
- Arithmetic: the sum wraps modulo 2^W, with no saturation and no overflow flag.
- `reqN_ready` is never asserted outside IDLE. A requester holds valid and data until it sees ready.
- `reqN_ready` is combinational from `reqN_valid`, state and `last_gnt`.
- There is no combinational path from `rsp_ready` to any output.

## Timing
- Reset (synchronous, takes priority over all other activity):
  - State = IDLE; `rsp_valid`, `req0_ready`, `req1_ready` and `busy` = 0.
  - `rsp_d`, `rsp_id`, `add_a` and `add_b` = 0; `last_gnt` = 1; `prec0` = `prec1` = W.
- Reset mid-operation (EXEC or RESP) discards the pending result. No `rsp_valid` is produced for it.
- Latency:
  - Grant in cycle T; `add_a`/`add_b` valid from T+1.
  - `rsp_d` captured at the end of T+1; `rsp_valid` high from T+2.
- Throughput: at best one result per 3 cycles, when `rsp_ready` is held high.
- The next grant happens in the cycle after the RESP handshake. There is no IDLE bypass.
- The external adder must settle within one clock period (the EXEC cycle).
- A `cfg_we` in the same cycle as a grant to the same requester does not apply to that grant; the old value is used.

## Test plan
- Reset, then req0 with a=5, b=7 at precision 32 → `req0_ready` pulses in cycle 0; `rsp_valid` in cycle 2 with `rsp_d`=12, `rsp_id`=0; `busy` low after the handshake.
- Both requesters valid every cycle, `rsp_ready`=1 → grants alternate 0,1,0,1 starting with 0; results every 3 cycles; neither requester starves over 20 operations.
- `cfg_we` with id 1 and prec 24 (W=32); req1 with a=0x000001FF, b=0x00000101 → operands 0x00000100 and 0x00000100; `rsp_d`=0x00000200.
- Clamp checks:
  - prec=0 is stored as 1: a=0x80000001, b=0x7FFFFFFF gives `rsp_d`=0x80000000.
  - prec=40 is stored as 32.
  - Wrap-around: a=0x7FFFFFFF, b=1 at prec 32 gives 0x80000000.
- `rsp_ready` held low for 10 cycles in RESP → `rsp_valid`, `rsp_d` and `rsp_id` stable; no `reqN_ready` while req0 and req1 wait; grant resumes the cycle after `rsp_ready`=1.
- `rst` asserted in EXEC → next cycle: state IDLE, all outputs 0, `prec` registers back to 32; no response for the discarded operation.
